// File: rtl/ref_clk_out_gen_pkg.sv
// rtl/ref_clk_out_gen_pkg.sv - shared types and defaults for the reference clock output generator
package ref_clk_out_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int REF_DIV_250_TO_10 = 25;
    localparam int REF_HIGH          = 13;

    // Minimum phase counter width able to hold DIV-1.
    function automatic int ref_cnt_w(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/ref_clk_out_gen.sv
// rtl/ref_clk_out_gen.sv - divides clk_250mhz to a glitch-free reference output with sync alignment
module ref_clk_out_gen
    import ref_clk_out_gen_pkg::*;
#(
    parameter int DIV         = REF_DIV_250_TO_10,
    parameter int HIGH        = REF_HIGH,
    parameter bit ALIGN_START = 1'b0,
    parameter int CNT_W       = 8
) (
    input  logic             clk_250mhz,
    input  logic             rst_250mhz_n,
    input  logic             enable,
    input  logic             sync_in,
    output logic             clk_out,
    output logic             clk_out_active,
    output logic [CNT_W-1:0] phase,
    output logic             sync_slip
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] C_HIGH = CNT_W'(HIGH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [CNT_W-1:0] w_count_inc;
    logic             r_clk_out;
    logic             w_clk_out_nxt;
    logic             r_active;
    logic             r_slip;
    logic             w_slip_nxt;
    logic             w_wrap;

    assign w_wrap      = (r_count == C_LAST);
    assign w_count_inc = w_wrap ? '0 : r_count + 1'b1;

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_clk_out_nxt = r_clk_out;
        w_slip_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    if (ALIGN_START) begin
                        w_state_nxt = ST_ARMED;
                    end else begin
                        w_state_nxt   = ST_RUN;
                        w_count_nxt   = '0;
                        w_clk_out_nxt = 1'b1;
                    end
                end
            end
            ST_ARMED: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (sync_in) begin
                    w_state_nxt   = ST_RUN;
                    w_count_nxt   = '0;
                    w_clk_out_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                // Sync restarts the period high, so a high pulse is stretched, never cut.
                if (sync_in) begin
                    w_count_nxt   = '0;
                    w_clk_out_nxt = 1'b1;
                    w_slip_nxt    = !w_wrap;
                end else begin
                    w_count_nxt   = w_count_inc;
                    w_clk_out_nxt = (w_count_inc < C_HIGH);
                end
                if (!enable) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (enable) begin
                    w_state_nxt   = ST_RUN;
                    w_count_nxt   = w_count_inc;
                    w_clk_out_nxt = (w_count_inc < C_HIGH);
                end else if (w_wrap) begin
                    w_state_nxt   = ST_IDLE;
                    w_count_nxt   = '0;
                    w_clk_out_nxt = 1'b0;
                end else begin
                    w_count_nxt   = w_count_inc;
                    w_clk_out_nxt = (w_count_inc < C_HIGH);
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_count_nxt   = '0;
                w_clk_out_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_250mhz or negedge rst_250mhz_n) begin
        if (!rst_250mhz_n) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_clk_out <= 1'b0;
            r_active  <= 1'b0;
            r_slip    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_clk_out <= w_clk_out_nxt;
            r_active  <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
            r_slip    <= w_slip_nxt;
        end
    end

    assign clk_out        = r_clk_out;
    assign clk_out_active = r_active;
    assign phase          = r_count;
    assign sync_slip      = r_slip;

endmodule

// File: tb/tb_ref_clk_out_gen.sv
// tb/tb_ref_clk_out_gen.sv - directed self-checking bench for ref_clk_out_gen
module tb_ref_clk_out_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_a = 1'b0, sync_a = 1'b0;
    logic       en_b = 1'b0, sync_b = 1'b0;
    logic       en_c = 1'b0, sync_c = 1'b0;
    logic       clk_a, act_a, slip_a;
    logic       clk_b, act_b, slip_b;
    logic       clk_c, act_c, slip_c;
    logic [7:0] ph_a, ph_b;
    logic [0:0] ph_c;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ref_clk_out_gen u_a (
        .clk_250mhz(clk), .rst_250mhz_n(rst_n), .enable(en_a), .sync_in(sync_a),
        .clk_out(clk_a), .clk_out_active(act_a), .phase(ph_a), .sync_slip(slip_a)
    );

    ref_clk_out_gen #(.ALIGN_START(1'b1)) u_b (
        .clk_250mhz(clk), .rst_250mhz_n(rst_n), .enable(en_b), .sync_in(sync_b),
        .clk_out(clk_b), .clk_out_active(act_b), .phase(ph_b), .sync_slip(slip_b)
    );

    ref_clk_out_gen #(.DIV(2), .HIGH(1), .CNT_W(1)) u_c (
        .clk_250mhz(clk), .rst_250mhz_n(rst_n), .enable(en_c), .sync_in(sync_c),
        .clk_out(clk_c), .clk_out_active(act_c), .phase(ph_c), .sync_slip(slip_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase_a(input int p);
        int n;
        n = 0;
        while (ph_a !== 8'(p) && n < 100) begin
            tick();
            n++;
        end
        vectors++;
        if (ph_a !== 8'(p)) begin
            miscompares++;
            $display("FAIL wait_phase_a: phase=%0d required=%0d (timeout)", ph_a, p);
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        vectors++;
        if ({clk_a, act_a, slip_a, ph_a} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_a: clk=%b act=%b slip=%b phase=%0d required all 0", clk_a, act_a, slip_a, ph_a);
        end
        vectors++;
        if ({clk_b, act_b, slip_b, ph_b, clk_c, act_c, slip_c, ph_c} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_bc: b=%b%b%b/%0d c=%b%b%b/%0d required all 0",
                     clk_b, act_b, slip_b, ph_b, clk_c, act_c, slip_c, ph_c);
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (clk_a !== 1'b0 || act_a !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: clk=%b act=%b required 0 0", clk_a, act_a);
        end
    endtask

    task automatic test_basic();
        en_a = 1'b1;
        tick();
        for (int i = 0; i < 50; i++) begin
            vectors++;
            if (ph_a !== 8'(i % 25) || clk_a !== ((i % 25) < 13) || act_a !== 1'b1) begin
                miscompares++;
                $display("FAIL basic[%0d]: phase=%0d clk=%b act=%b required phase=%0d clk=%b act=1",
                         i, ph_a, clk_a, act_a, i % 25, (i % 25) < 13);
            end
            tick();
        end
    endtask

    task automatic test_drain();
        wait_phase_a(5);
        en_a = 1'b0;
        for (int p = 6; p < 25; p++) begin
            tick();
            vectors++;
            if (ph_a !== 8'(p) || clk_a !== (p < 13) || act_a !== 1'b1) begin
                miscompares++;
                $display("FAIL drain[%0d]: phase=%0d clk=%b act=%b required phase=%0d clk=%b act=1",
                         p, ph_a, clk_a, act_a, p, p < 13);
            end
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (ph_a !== 8'd0 || clk_a !== 1'b0 || act_a !== 1'b0) begin
                miscompares++;
                $display("FAIL drain_idle[%0d]: phase=%0d clk=%b act=%b required 0 0 0", k, ph_a, clk_a, act_a);
            end
        end
    endtask

    task automatic test_sync();
        int hi, lo, n;
        en_a = 1'b1;
        tick();
        wait_phase_a(24);
        sync_a = 1'b1;
        tick();
        sync_a = 1'b0;
        vectors++;
        if (slip_a !== 1'b0 || ph_a !== 8'd0 || clk_a !== 1'b1) begin
            miscompares++;
            $display("FAIL aligned_sync: slip=%b phase=%0d clk=%b required 0 0 1", slip_a, ph_a, clk_a);
        end
        hi = 1;
        for (int k = 0; k < 7; k++) begin
            tick();
            if (clk_a === 1'b1) hi++;
        end
        sync_a = 1'b1;
        tick();
        sync_a = 1'b0;
        if (clk_a === 1'b1) hi++;
        vectors++;
        if (slip_a !== 1'b1 || ph_a !== 8'd0) begin
            miscompares++;
            $display("FAIL slip_sync: slip=%b phase=%0d required 1 0", slip_a, ph_a);
        end
        tick();
        if (clk_a === 1'b1) hi++;
        vectors++;
        if (slip_a !== 1'b0 || ph_a !== 8'd1) begin
            miscompares++;
            $display("FAIL slip_one_cycle: slip=%b phase=%0d required 0 1", slip_a, ph_a);
        end
        n = 0;
        tick();
        while (clk_a === 1'b1 && n < 60) begin
            hi++;
            tick();
            n++;
        end
        vectors++;
        if (hi !== 21) begin
            miscompares++;
            $display("FAIL stretched_high: high_cycles=%0d required 21", hi);
        end
        lo = 0;
        n = 0;
        while (clk_a === 1'b0 && n < 60) begin
            lo++;
            tick();
            n++;
        end
        hi = 0;
        n = 0;
        while (clk_a === 1'b1 && n < 60) begin
            hi++;
            tick();
            n++;
        end
        vectors++;
        if (lo !== 12 || hi !== 13) begin
            miscompares++;
            $display("FAIL post_sync_period: low=%0d high=%0d required 12 13", lo, hi);
        end
    endtask

    task automatic test_async_reset();
        wait_phase_a(3);
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (clk_a !== 1'b0 || act_a !== 1'b0 || ph_a !== 8'd0) begin
            miscompares++;
            $display("FAIL async_reset: clk=%b act=%b phase=%0d required 0 0 0", clk_a, act_a, ph_a);
        end
        tick();
        rst_n = 1'b1;
        tick();
        vectors++;
        if (ph_a !== 8'd0 || clk_a !== 1'b1 || act_a !== 1'b1) begin
            miscompares++;
            $display("FAIL restart: phase=%0d clk=%b act=%b required 0 1 1", ph_a, clk_a, act_a);
        end
        tick();
        vectors++;
        if (ph_a !== 8'd1 || clk_a !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_count: phase=%0d clk=%b required 1 1", ph_a, clk_a);
        end
    endtask

    task automatic test_align_start();
        int bad;
        bad = 0;
        en_b = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (clk_b !== 1'b0 || act_b !== 1'b0) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL armed_quiet: active_cycles=%0d required 0", bad);
        end
        sync_b = 1'b1;
        tick();
        sync_b = 1'b0;
        vectors++;
        if (clk_b !== 1'b1 || ph_b !== 8'd0 || act_b !== 1'b1) begin
            miscompares++;
            $display("FAIL armed_start: clk=%b phase=%0d act=%b required 1 0 1", clk_b, ph_b, act_b);
        end
        tick();
        vectors++;
        if (clk_b !== 1'b1 || ph_b !== 8'd1) begin
            miscompares++;
            $display("FAIL armed_count: clk=%b phase=%0d required 1 1", clk_b, ph_b);
        end
    endtask

    task automatic test_div2_drain_reenable();
        en_c = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (ph_c !== 1'(i % 2) || clk_c !== ((i % 2) == 0) || act_c !== 1'b1) begin
                miscompares++;
                $display("FAIL div2[%0d]: phase=%0d clk=%b act=%b required phase=%0d clk=%b act=1",
                         i, ph_c, clk_c, act_c, i % 2, (i % 2) == 0);
            end
            tick();
        end
        en_c = 1'b0;
        tick();
        vectors++;
        if (ph_c !== 1'b1 || clk_c !== 1'b0 || act_c !== 1'b1) begin
            miscompares++;
            $display("FAIL div2_drain: phase=%0d clk=%b act=%b required 1 0 1", ph_c, clk_c, act_c);
        end
        en_c = 1'b1;
        tick();
        vectors++;
        if (ph_c !== 1'b0 || clk_c !== 1'b1 || act_c !== 1'b1) begin
            miscompares++;
            $display("FAIL div2_reenable: phase=%0d clk=%b act=%b required 0 1 1", ph_c, clk_c, act_c);
        end
        tick();
        vectors++;
        if (ph_c !== 1'b1 || clk_c !== 1'b0 || act_c !== 1'b1) begin
            miscompares++;
            $display("FAIL div2_resume: phase=%0d clk=%b act=%b required 1 0 1", ph_c, clk_c, act_c);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drain();
        test_sync();
        test_async_reset();
        test_align_start();
        test_div2_drain_reenable();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
